// File: rtl/byte_frame_rx.sv
// byte_frame_rx
//   Frame receiver: hunts for SOF, reads a length byte, stores the payload
//   in an internal buffer while accumulating an XOR checksum, and only
//   releases the payload on the output handshake once the checksum byte
//   matches (store-and-forward). Bad length or bad checksum drops the frame
//   and pulses frame_err.
//
// Parameters
//   MAX_LEN  payload buffer depth / largest legal length (1..255)
//   SOF      start-of-frame byte value
//   ERR_W    error counter width (only with RX_ERR_CNT_EN)
//
// Ports
//   clk, rst             clock, asynchronous active-low reset
//   in_data/valid/ready  input byte stream (ready low only while draining)
//   out_data/valid/last  payload output, out_last marks final byte
//   out_ready            consumer accept
//   frame_ok, frame_err  one-cycle pulses after the frame's last byte
//   err_cnt              saturating dropped-frame counter
//
// Optional feature: define RX_ERR_CNT_EN to add the err_cnt port/counter.

module byte_frame_rx #(
    parameter int         MAX_LEN = 8,
    parameter logic [7:0] SOF     = 8'hA5
`ifdef RX_ERR_CNT_EN
    ,parameter int        ERR_W   = 8
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       out_data,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready,
    output logic             frame_ok,
    output logic             frame_err
`ifdef RX_ERR_CNT_EN
    ,output logic [ERR_W-1:0] err_cnt
`endif
);

    localparam int PW = $clog2(MAX_LEN + 1);
    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [2:0] {HUNT, LEN, PAY, CSUM, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [7:0]    len_q, len_d;
    logic [7:0]    csum_q, csum_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          frame_ok_q, frame_ok_d;
    logic          frame_err_q, frame_err_d;
    logic [PW-1:0] wr_ptr_inc;
    logic          buf_we;
    logic          in_xfer;
    logic [7:0]    buf_q [MAX_LEN];

    // Handshake and outputs come from registered state only.
    assign in_ready  = (state_q != DRAIN);
    assign in_xfer   = in_valid && in_ready;
    assign out_valid = (state_q == DRAIN);
    // Gated so out_data reads 0 whenever nothing is being presented.
    assign out_data  = out_valid ? buf_q[rd_ptr_q[IW-1:0]] : 8'h00;
    assign out_last  = out_valid && ((8'(rd_ptr_q) + 8'd1) == len_q);
    assign frame_ok  = frame_ok_q;
    assign frame_err = frame_err_q;

    assign wr_ptr_inc = wr_ptr_q + PW'(1);

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        csum_d      = csum_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        buf_we      = 1'b0;
        case (state_q)
            HUNT: begin
                if (in_xfer && in_data == SOF) state_d = LEN;
            end
            LEN: begin
                if (in_xfer) begin
                    len_d = in_data;
                    if (in_data == 8'd0 || in_data > 8'(MAX_LEN)) begin
                        frame_err_d = 1'b1;
                        state_d     = HUNT;
                    end else begin
                        wr_ptr_d = '0;
                        csum_d   = 8'h00;
                        state_d  = PAY;
                    end
                end
            end
            PAY: begin
                if (in_xfer) begin
                    buf_we   = 1'b1;
                    wr_ptr_d = wr_ptr_inc;
                    csum_d   = csum_q ^ in_data;
                    if (8'(wr_ptr_inc) == len_q) state_d = CSUM;
                end
            end
            CSUM: begin
                if (in_xfer) begin
                    if (in_data == csum_q) begin
                        frame_ok_d = 1'b1;
                        rd_ptr_d   = '0;
                        state_d    = DRAIN;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = HUNT;
                    end
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    rd_ptr_d = rd_ptr_q + PW'(1);
                    if (out_last) state_d = HUNT;
                end
            end
            default: state_d = HUNT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= HUNT;
            len_q       <= 8'h00;
            csum_q      <= 8'h00;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            csum_q      <= csum_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Payload storage carries no reset: contents are only visible in DRAIN,
    // which is reachable solely after a complete rewrite of 0..len-1.
    always_ff @(posedge clk) begin
        if (buf_we) buf_q[wr_ptr_q[IW-1:0]] <= in_data;
    end

`ifdef RX_ERR_CNT_EN
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (frame_err_q && !(&err_cnt_q)) err_cnt_d = err_cnt_q + ERR_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err_cnt_q <= '0;
        else      err_cnt_q <= err_cnt_d;
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_byte_frame_rx.sv
// Scoreboard bench for byte_frame_rx. A reference parser walks each
// stimulus byte stream using the framing rules and queues the expected
// pulses and payload bytes; a monitor pops and compares whenever the DUT
// pulses or transfers an output byte.
module tb_byte_frame_rx;
    localparam int         MAX_LEN = 8;
    localparam logic [7:0] SOF     = 8'hA5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid, out_last;
    logic       out_ready;
    logic       frame_ok, frame_err;
`ifdef RX_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    byte_frame_rx #(.MAX_LEN(MAX_LEN), .SOF(SOF)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
        .out_ready(out_ready),
        .frame_ok(frame_ok), .frame_err(frame_err)
`ifdef RX_ERR_CNT_EN
        , .err_cnt(err_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { bit ok; int idx; } ev_t;
    typedef struct { logic [7:0] d; bit last; } ob_t;

    ev_t        exp_ev[$];
    ob_t        exp_ob[$];
    time        acc_t[$];
    logic [7:0] stim[$];
    int         tests = 0;
    int         fails = 0;
    int         err_exp = 0;
    int         or_mode = 0;   // 0: out_ready=1, 1: random, 2: held low
    bit         gaps = 1'b0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void fail_msg(input string nm);
        tests++;
        fails++;
        $display("FAIL %s at %0t", nm, $time);
    endfunction

    // Reference parser: plain walk over the byte list.
    task automatic model_stream();
        int i = 0;
        int len;
        logic [7:0] x;
        while (i < stim.size()) begin
            if (stim[i] != SOF) begin i++; continue; end
            if (i + 1 >= stim.size()) break;
            len = int'(stim[i+1]);
            if (len == 0 || len > MAX_LEN) begin
                exp_ev.push_back('{1'b0, i + 1});
                err_exp++;
                i += 2;
                continue;
            end
            if (i + 2 + len >= stim.size()) break;
            x = 8'h00;
            for (int k = 0; k < len; k++) x ^= stim[i+2+k];
            if (stim[i+2+len] == x) begin
                exp_ev.push_back('{1'b1, i + 2 + len});
                for (int k = 0; k < len; k++) exp_ob.push_back('{stim[i+2+k], k == len - 1});
            end else begin
                exp_ev.push_back('{1'b0, i + 2 + len});
                err_exp++;
            end
            i += len + 3;
        end
    endtask

    task automatic add_good(input int len);
        logic [7:0] x = 8'h00, b;
        stim.push_back(SOF);
        stim.push_back(8'(len));
        for (int k = 0; k < len; k++) begin b = 8'($urandom); x ^= b; stim.push_back(b); end
        stim.push_back(x);
    endtask

    task automatic add_badcs(input int len);
        logic [7:0] x = 8'h00, b;
        stim.push_back(SOF);
        stim.push_back(8'(len));
        for (int k = 0; k < len; k++) begin b = 8'($urandom); x ^= b; stim.push_back(b); end
        stim.push_back(x ^ 8'($urandom_range(1, 255)));
    endtask

    task automatic add_badlen();
        stim.push_back(SOF);
        stim.push_back($urandom_range(0, 1) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255)));
    endtask

    task automatic add_garbage(input int n);
        logic [7:0] b;
        for (int k = 0; k < n; k++) begin
            b = 8'($urandom);
            if (b == SOF) b = 8'h3C;
            stim.push_back(b);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        if (gaps && $urandom_range(0, 3) == 0) begin in_valid = 1'b0; @(negedge clk); end
        while (!in_ready && n < 2000) begin in_valid = 1'b0; @(negedge clk); n++; end
        if (n >= 2000) fail_msg("in_ready_timeout");
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        acc_t.push_back($time);
    endtask

    task automatic send_stim();
        acc_t.delete();
        foreach (stim[k]) send_byte(stim[k]);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_ev.size() != 0 || exp_ob.size() != 0 || out_valid) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) fail_msg("drain_timeout");
        repeat (2) @(negedge clk);
    endtask

    task automatic check_cnt();
`ifdef RX_ERR_CNT_EN
        chk("err_cnt", {24'h0, err_cnt}, (err_exp > 255) ? 255 : err_exp);
`endif
    endtask

    task automatic run_phase();
        model_stream();
        send_stim();
        wait_drain();
        check_cnt();
        stim.delete();
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"},  in_ready,  1);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"},  out_data,  0);
        chk({tag, "_out_last"},  out_last,  0);
        chk({tag, "_frame_ok"},  frame_ok,  0);
        chk({tag, "_frame_err"}, frame_err, 0);
`ifdef RX_ERR_CNT_EN
        chk({tag, "_err_cnt"},   {24'h0, err_cnt}, 0);
`endif
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk);
        #1 rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check_reset_vals(tag);
        exp_ev.delete();
        exp_ob.delete();
        acc_t.delete();
        stim.delete();
        err_exp = 0;
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // Monitor: pops expectations on pulses and output transfers; also owns out_ready.
    initial begin : mon
        bit         prev_stall = 1'b0;
        bit         ordy;
        logic [7:0] pd = 8'h00;
        bit         pl = 1'b0;
        ev_t        e;
        ob_t        o;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin prev_stall = 1'b0; continue; end
            chk("in_ready_vs_drain", in_ready, !out_valid);
            if (frame_ok || frame_err) begin
                if (exp_ev.size() == 0) fail_msg("unexpected_pulse");
                else begin
                    e = exp_ev.pop_front();
                    chk("pulse_kind", {30'h0, frame_ok, frame_err}, e.ok ? 2 : 1);
                    if (e.idx < acc_t.size()) chk("pulse_timing", 32'($time - acc_t[e.idx]), 5);
                    if (e.ok) chk("ok_with_out_valid", out_valid, 1);
                    else      chk("err_no_out_valid", out_valid, 0);
                end
            end
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, pd);
                chk("stall_last", out_last, pl);
            end
            case (or_mode)
                0:       ordy = 1'b1;
                1:       ordy = 1'($urandom_range(0, 1));
                default: ordy = 1'b0;
            endcase
            out_ready = ordy;
            if (out_valid && ordy) begin
                if (exp_ob.size() == 0) fail_msg("unexpected_out_byte");
                else begin
                    o = exp_ob.pop_front();
                    chk("out_data", out_data, o.d);
                    chk("out_last", out_last, o.last);
                end
                prev_stall = 1'b0;
            end else begin
                prev_stall = out_valid;
            end
            pd = out_data;
            pl = out_last;
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [7:0] x;
        repeat (2) @(negedge clk);
        check_reset_vals("por");
        @(posedge clk);
        #1 rst = 1'b1;

        // Good frame, consumer always ready.
        or_mode = 0;
        stim = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h00};
        run_phase();

        // Bad checksum.
        stim = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h31};
        run_phase();

        // Leading garbage then two bad lengths.
        stim = '{8'h3C, 8'h5A, 8'hA5, 8'h00, 8'hA5, 8'(MAX_LEN + 1)};
        run_phase();

        // Backpressure on a len-4 frame.
        or_mode = 1;
        add_good(4);
        run_phase();

        // Full buffer with SOF values inside the payload.
        stim = '{8'hA5, 8'h08, 8'h01, 8'hA5, 8'h03, 8'hA5, 8'h05, 8'h06, 8'h07, 8'h08};
        x = 8'h00;
        for (int k = 2; k < 10; k++) x ^= stim[k];
        stim.push_back(x);
        run_phase();

        // Random mix of frame kinds with input gaps and random out_ready.
        gaps = 1'b1;
        for (int f = 0; f < 40; f++) begin
            case ($urandom_range(0, 3))
                0: add_good($urandom_range(1, MAX_LEN));
                1: add_badcs($urandom_range(1, MAX_LEN));
                2: add_badlen();
                default: add_garbage($urandom_range(1, 3));
            endcase
        end
        run_phase();
        gaps = 1'b0;

        // Reset in the middle of the payload.
        stim = '{8'hA5, 8'h04, 8'h01, 8'h02};
        model_stream();
        send_stim();
        do_reset("rst_pay");
        add_good(3);
        run_phase();

        // Reset while a verified frame is stalled in drain.
        or_mode = 2;
        add_good(5);
        model_stream();
        send_stim();
        begin
            int n = 0;
            while (exp_ev.size() != 0 && n < 100) begin @(negedge clk); n++; end
            if (n >= 100) fail_msg("ok_timeout");
        end
        repeat (3) @(negedge clk);
        chk("drain_stalled", out_valid, 1);
        do_reset("rst_drain");
        or_mode = 1;
        add_good(MAX_LEN);
        run_phase();

        // Error counter saturation.
        or_mode = 0;
        for (int f = 0; f < 260; f++) begin stim.push_back(SOF); stim.push_back(8'h00); end
        run_phase();

        chk("leftover_events", exp_ev.size(), 0);
        chk("leftover_bytes", exp_ob.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/byte_frame_rx.md
# byte_frame_rx

Downstream consumer of the off-chip link receiver's byte stream: takes reassembled bytes over a valid/ready handshake, delineates frames (SOF, length, payload, XOR checksum), and buffers each payload internally. The payload is released on a second valid/ready interface only after its checksum verifies (store-and-forward). Corrupt or malformed frames are dropped whole and flagged.

## Interface
Parameters:
- MAX_LEN, 8, payload buffer depth in bytes; largest legal length field (1..255).
- SOF, 8'hA5, start-of-frame byte value.
- ERR_W, 8, width of the error counter (only with RX_ERR_CNT_EN).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset, asynchronous, active-low; one clock domain.
- in_data  input  8  incoming byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block accepts a byte this cycle.
- out_data  output  8  payload byte.
- out_valid  output  1  out_data valid.
- out_last  output  1  out_data is the final payload byte of the frame.
- out_ready  input  1  consumer accepts out_data.
- frame_ok  output  1  one-cycle pulse: frame checksum matched.
- frame_err  output  1  one-cycle pulse: frame dropped.
- err_cnt  output  ERR_W  dropped-frame count (only with RX_ERR_CNT_EN).

## Operation
- Input transfer: in_valid && in_ready at a rising edge. Output transfer: out_valid && out_ready.
- States: HUNT, LEN, PAY, CSUM, DRAIN. in_ready = 1 in HUNT/LEN/PAY/CSUM, 0 in DRAIN.
- HUNT: byte == SOF -> LEN; any other byte discarded silently (no error).
- LEN: byte stored as len. len == 0 or len > MAX_LEN -> frame_err, HUNT. Else clear wr_ptr, clear csum, -> PAY.
- PAY: byte written to buf[wr_ptr], wr_ptr++, csum ^= byte. After len-th byte -> CSUM.
- CSUM: byte == csum -> frame_ok, rd_ptr = 0, -> DRAIN. Mismatch -> frame_err, -> HUNT (buffer contents discarded).
- SOF value inside LEN/PAY/CSUM is ordinary data; no resync mid-frame.
- DRAIN: out_valid = 1, out_data = buf[rd_ptr], out_last = (rd_ptr == len-1). On transfer rd_ptr++; transfer with out_last -> HUNT.
- out_valid/out_data/out_last depend only on registered state (no combinational input-to-output path). in_ready depends only on state.
- Width rules: len 8 bits; wr_ptr/rd_ptr $clog2(MAX_LEN+1) bits; csum 8 bits XOR over payload only (SOF and length excluded).
- Boundary: len == MAX_LEN fills buffer exactly, legal. out_ready held low in DRAIN stalls indefinitely with out_data/out_last stable. out_ready ignored outside DRAIN.

## Timing
- Reset values: in_ready 1 (state HUNT), out_valid 0, out_data 0, out_last 0, frame_ok 0, frame_err 0, err_cnt 0; pointers, len, csum cleared.
- Reset asserted mid-frame or mid-drain: everything returns to reset values immediately; partial/undrained frame lost, no pulse.
- Checksum byte accepted at edge t: frame_ok (or frame_err) high for the cycle following t; out_valid high in that same cycle with payload byte 0.
- Bad length accepted at edge t: frame_err high for cycle after t, in_ready stays 1.
- Back-to-back: with out_ready held 1, a frame of len N occupies DRAIN for N cycles; in_ready returns to 1 the cycle after the last out transfer, so the next SOF is accepted no earlier than that edge.
- Minimum frame spacing on input: N+3 accepted bytes per frame; no bubble required between CSUM and next SOF except during DRAIN.

## Configuration
- RX_ERR_CNT_EN defined: err_cnt port exists; increments by 1 on each frame_err cycle, saturates at all-ones, cleared only by reset.
- Not defined: err_cnt port and counter absent; frame_err pulse unchanged.

## Test plan
- Good frame: A5,03,11,22,33,00 with out_ready=1 -> frame_ok one cycle, out 11,22,33 on consecutive cycles, out_last only on 33, then in_ready=1.
- Bad checksum: A5,02,10,20,31 -> frame_err one cycle, out_valid never asserts, err_cnt 0->1 (macro on).
- Bad length: A5,00 then A5,(MAX_LEN+1) -> two frame_err pulses, back in HUNT; leading garbage 3C,5A before A5 ignored without error.
- Backpressure: good frame len 4, out_ready toggled 1,0,0,1,... -> each byte held stable while stalled, exactly 4 transfers, in_ready=0 throughout DRAIN.
- Full buffer + embedded SOF: A5,08 then eight payload bytes including A5, correct XOR -> all 8 bytes delivered in order.
- Reset mid-PAY and mid-DRAIN: rst low one cycle -> outputs at reset values, then a fresh good frame passes normally; err_cnt saturates at 8'hFF after 256+ bad frames.
